// File: rtl/cp0_regs.sv
// cp0_regs: Coprocessor-0 register block at the write-back end of the pipeline.
//
// Holds BadVAddr, Count, Compare, Status, Cause and EPC. It takes MTC0 commits
// from MEM/WB and exception/ERET commits from the exception unit, and raises
// the interrupt request. The MFC0 read port is combinational and bypasses a
// write to the same register that is committing in the same cycle.
//
// Build option: define CP0_TIMER_EN to include the Count/Compare timer and the
// TI interrupt. Without it, addresses 9 and 11 read 0 and TI is constant 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_cp0_write_enable/addr/data   MTC0 commit port
//   read_addr, read_data     MFC0 read port (combinational, bypassed)
//   hw_int                   external interrupt levels (registered once)
//   exception, exc_code, exc_pc, exc_in_delay_slot, exc_badvaddr
//                            exception commit pulse and its attributes
//   eret                     ERET commit pulse
//   status_o, cause_o, epc_o current register values
//   int_req                  interrupt pending and enabled
module cp0_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cp0_write_enable,
    input  logic [4:0]  wb_cp0_write_addr,
    input  logic [31:0] wb_cp0_write_data,
    input  logic [4:0]  read_addr,
    output logic [31:0] read_data,
    input  logic [5:0]  hw_int,
    input  logic        exception,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_delay_slot,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        int_req
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [5:0]  hw_int_q, hw_int_d;
    logic        ti;
    logic        mtc0_commit;
    logic [5:0]  ip_hw;
    logic [31:0] status_val, cause_val;

    // An MTC0 only takes effect when neither an exception nor an ERET commits
    // in the same cycle; the lower-priority event is simply lost.
    assign mtc0_commit = wb_cp0_write_enable & ~exception & ~eret;

    assign ip_hw      = {hw_int_q[5] | ti, hw_int_q[4:0]};
    assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_val  = {bd_q, ti, 14'b0, ip_hw, ip_sw_q, 1'b0, exc_code_q, 2'b0};

    assign status_o = status_val;
    assign cause_o  = cause_val;
    assign epc_o    = epc_q;
    assign int_req  = ie_q & ~exl_q & (|(im_q & cause_val[15:8]));

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tick_q, tick_d;
    logic        ti_q, ti_d;

    assign ti = ti_q;

    // Timer: Count advances on every other cycle. TI latches when the stored
    // Count matches the stored Compare, and a committed Compare write clears
    // it, overriding a set in the same cycle.
    always_comb begin
        tick_d    = ~tick_q;
        count_d   = count_q + {31'b0, tick_q};
        compare_d = compare_q;
        ti_d      = ti_q | (count_q == compare_q);
        if (mtc0_commit && (wb_cp0_write_addr == ADDR_COUNT)) begin
            count_d = wb_cp0_write_data;
        end
        if (mtc0_commit && (wb_cp0_write_addr == ADDR_COMPARE)) begin
            compare_d = wb_cp0_write_data;
            ti_d      = 1'b0;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'b0;
            compare_q <= 32'b0;
            tick_q    <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tick_q    <= tick_d;
            ti_q      <= ti_d;
        end
    end
`else
    assign ti = 1'b0;
`endif

    // Next-state for the architectural registers. Exceptions only update EPC
    // and BD when not already at exception level, so nested faults keep the
    // original return address.
    always_comb begin
        badvaddr_d = badvaddr_q;
        epc_d      = epc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exc_code_d = exc_code_q;
        hw_int_d   = hw_int;
        if (exception) begin
            if (!exl_q) begin
                epc_d = exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
                bd_d  = exc_in_delay_slot;
            end
            exl_d      = 1'b1;
            exc_code_d = exc_code;
            if ((exc_code == 5'd4) || (exc_code == 5'd5)) begin
                badvaddr_d = exc_badvaddr;
            end
        end else if (eret) begin
            exl_d = 1'b0;
        end
        if (mtc0_commit) begin
            case (wb_cp0_write_addr)
                ADDR_STATUS: begin
                    im_d  = wb_cp0_write_data[15:8];
                    exl_d = wb_cp0_write_data[1];
                    ie_d  = wb_cp0_write_data[0];
                end
                ADDR_CAUSE: ip_sw_d = wb_cp0_write_data[9:8];
                ADDR_EPC:   epc_d   = wb_cp0_write_data;
                default: ;
            endcase
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_q <= 32'b0;
            epc_q      <= 32'b0;
            im_q       <= 8'b0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_sw_q    <= 2'b0;
            exc_code_q <= 5'b0;
            hw_int_q   <= 6'b0;
        end else begin
            badvaddr_q <= badvaddr_d;
            epc_q      <= epc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            hw_int_q   <= hw_int_d;
        end
    end

    // MFC0 read mux. A write to the register being read returns the value
    // that write will leave behind, after masking off read-only fields.
    always_comb begin
        logic bypass;
        bypass    = wb_cp0_write_enable && (wb_cp0_write_addr == read_addr);
        read_data = 32'b0;
        case (read_addr)
            ADDR_BADVADDR: read_data = badvaddr_q;
            ADDR_STATUS:   read_data = bypass ?
                {9'b0, 1'b1, 6'b0, wb_cp0_write_data[15:8], 6'b0, wb_cp0_write_data[1:0]} :
                status_val;
            ADDR_CAUSE:    read_data = bypass ?
                {bd_q, ti, 14'b0, ip_hw, wb_cp0_write_data[9:8], 1'b0, exc_code_q, 2'b0} :
                cause_val;
            ADDR_EPC:      read_data = bypass ? wb_cp0_write_data : epc_q;
`ifdef CP0_TIMER_EN
            ADDR_COUNT:    read_data = bypass ? wb_cp0_write_data : count_q;
            ADDR_COMPARE:  read_data = bypass ? wb_cp0_write_data : compare_q;
`endif
            default:       read_data = 32'b0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: directed, table-driven bench for cp0_regs, plus hand-written
// sequences for reset, the timer and a reset arriving mid-operation.
module tb_cp0_regs;

    logic        clk;
    logic        rst;
    logic        wb_cp0_write_enable;
    logic [4:0]  wb_cp0_write_addr;
    logic [31:0] wb_cp0_write_data;
    logic [4:0]  read_addr;
    logic [31:0] read_data;
    logic [5:0]  hw_int;
    logic        exception;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay_slot;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        int_req;

    int testsRun;
    int testsFailed;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] badv;
        logic        er;
        logic [5:0]  hw;
        logic [31:0] expRead;
        logic        expInt;
    } vec_t;

    vec_t vecs[$];

    cp0_regs dut (
        .clk                 (clk),
        .rst                 (rst),
        .wb_cp0_write_enable (wb_cp0_write_enable),
        .wb_cp0_write_addr   (wb_cp0_write_addr),
        .wb_cp0_write_data   (wb_cp0_write_data),
        .read_addr           (read_addr),
        .read_data           (read_data),
        .hw_int              (hw_int),
        .exception           (exception),
        .exc_code            (exc_code),
        .exc_pc              (exc_pc),
        .exc_in_delay_slot   (exc_in_delay_slot),
        .exc_badvaddr        (exc_badvaddr),
        .eret                (eret),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .int_req             (int_req)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic we, input logic [4:0] waddr,
                                input logic [31:0] wdata, input logic [4:0] raddr,
                                input logic exc, input logic [4:0] code,
                                input logic [31:0] pc, input logic ds,
                                input logic [31:0] badv, input logic er,
                                input logic [5:0] hw, input logic [31:0] expRead,
                                input logic expInt);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr;
        v.exc = exc; v.code = code; v.pc = pc; v.ds = ds; v.badv = badv;
        v.er = er; v.hw = hw; v.expRead = expRead; v.expInt = expInt;
        return v;
    endfunction

    // Shorthands for read-only and write+read vectors with no events.
    function automatic vec_t rd(input logic [4:0] raddr, input logic [5:0] hw,
                                input logic [31:0] expRead, input logic expInt);
        return mk(1'b0, 5'd0, 32'd0, raddr, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0,
                  hw, expRead, expInt);
    endfunction

    function automatic vec_t wr(input logic [4:0] waddr, input logic [31:0] wdata,
                                input logic [4:0] raddr, input logic [31:0] expRead,
                                input logic expInt);
        return mk(1'b1, waddr, wdata, raddr, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0,
                  6'd0, expRead, expInt);
    endfunction

    task automatic applyStimulus(input vec_t v);
        wb_cp0_write_enable = v.we;
        wb_cp0_write_addr   = v.waddr;
        wb_cp0_write_data   = v.wdata;
        read_addr           = v.raddr;
        exception           = v.exc;
        exc_code            = v.code;
        exc_pc              = v.pc;
        exc_in_delay_slot   = v.ds;
        exc_badvaddr        = v.badv;
        eret                = v.er;
        hw_int              = v.hw;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    initial begin
        int found;
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        applyStimulus(rd(5'd12, 6'd0, 32'd0, 1'b0));

        // Vector table: inputs applied at the falling edge, outputs compared
        // before the next rising edge, so state effects appear one row later.
        vecs.push_back(wr(5'd11, 32'hFFFF_FFFF, 5'd12, 32'h0040_0000, 1'b0));
        vecs.push_back(wr(5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF03, 1'b0));
        vecs.push_back(rd(5'd12, 6'd0, 32'h0040_FF03, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 32'd0, 5'd13, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0,
                          1'b1, 6'd0, 32'h0, 1'b0));
        vecs.push_back(rd(5'd12, 6'd0, 32'h0040_FF01, 1'b0));
        vecs.push_back(wr(5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300, 1'b0));
        vecs.push_back(rd(5'd13, 6'd0, 32'h0000_0300, 1'b1));
        vecs.push_back(wr(5'd13, 32'h0, 5'd8, 32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 5'd0, 32'd0, 5'd13, 1'b1, 5'd4, 32'hBFC0_0100, 1'b1,
                          32'h1234_5679, 1'b0, 6'd0, 32'h0, 1'b0));
        vecs.push_back(rd(5'd14, 6'd0, 32'hBFC0_00FC, 1'b0));
        vecs.push_back(rd(5'd13, 6'd0, 32'h8000_0010, 1'b0));
        vecs.push_back(rd(5'd8,  6'd0, 32'h1234_5679, 1'b0));
        vecs.push_back(rd(5'd12, 6'd0, 32'h0040_FF03, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 32'd0, 5'd14, 1'b1, 5'd12, 32'h8000_0000, 1'b0,
                          32'hFFFF_FFFF, 1'b0, 6'd0, 32'hBFC0_00FC, 1'b0));
        vecs.push_back(rd(5'd14, 6'd0, 32'hBFC0_00FC, 1'b0));
        vecs.push_back(rd(5'd13, 6'd0, 32'h8000_0030, 1'b0));
        vecs.push_back(rd(5'd8,  6'd0, 32'h1234_5679, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 32'd0, 5'd12, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0,
                          1'b1, 6'd0, 32'h0040_FF03, 1'b0));
        vecs.push_back(rd(5'd12, 6'd0, 32'h0040_FF01, 1'b0));
        vecs.push_back(mk(1'b1, 5'd14, 32'h5555_5555, 5'd8, 1'b1, 5'd5, 32'h0040_0020,
                          1'b0, 32'hDEAD_BEEF, 1'b0, 6'd0, 32'h1234_5679, 1'b0));
        vecs.push_back(rd(5'd14, 6'd0, 32'h0040_0020, 1'b0));
        vecs.push_back(rd(5'd13, 6'd0, 32'h0000_0014, 1'b0));
        vecs.push_back(rd(5'd8,  6'd0, 32'hDEAD_BEEF, 1'b0));
        vecs.push_back(mk(1'b1, 5'd12, 32'h0, 5'd13, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0,
                          1'b1, 6'd0, 32'h0000_0014, 1'b0));
        vecs.push_back(rd(5'd12, 6'd0, 32'h0040_FF01, 1'b0));
        vecs.push_back(wr(5'd12, 32'h0000_0401, 5'd0, 32'h0, 1'b0));
        vecs.push_back(wr(5'd7, 32'hFFFF_FFFF, 5'd7, 32'h0, 1'b0));
        vecs.push_back(rd(5'd13, 6'b000001, 32'h0000_0014, 1'b0));
        vecs.push_back(rd(5'd13, 6'b000001, 32'h0000_0414, 1'b1));
        vecs.push_back(rd(5'd13, 6'b000000, 32'h0000_0414, 1'b1));
        vecs.push_back(rd(5'd13, 6'b000000, 32'h0000_0014, 1'b0));
        vecs.push_back(wr(5'd14, 32'hCAFE_F00D, 5'd14, 32'hCAFE_F00D, 1'b0));
        vecs.push_back(rd(5'd14, 6'b000000, 32'hCAFE_F00D, 1'b0));
        vecs.push_back(rd(5'd13, 6'b100000, 32'h0000_0014, 1'b0));
        vecs.push_back(rd(5'd13, 6'b000000, 32'h0000_8014, 1'b0));
        vecs.push_back(rd(5'd13, 6'b000000, 32'h0000_0014, 1'b0));

        // Reset state, observed while reset is still asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        read_addr = 5'd12; #1 checkOutput("reset_status", read_data, 32'h0040_0000);
        read_addr = 5'd13; #1 checkOutput("reset_cause", read_data, 32'h0);
        read_addr = 5'd14; #1 checkOutput("reset_epc", read_data, 32'h0);
        checkOutput("reset_int_req", {31'b0, int_req}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = 1'b0;
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_read", i), read_data, vecs[i].expRead);
            checkOutput($sformatf("vec%0d_int", i), {31'b0, int_req}, {31'b0, vecs[i].expInt});
        end

`ifdef CP0_TIMER_EN
        // Count=0, Compare=5, then enable IM[7]/IE; TI must appear 10 or 11
        // edges after the Count write depending on the tick phase.
        @(negedge clk); applyStimulus(wr(5'd9, 32'h0, 5'd0, 32'h0, 1'b0));
        @(negedge clk); applyStimulus(wr(5'd11, 32'd5, 5'd0, 32'h0, 1'b0));
        @(negedge clk); applyStimulus(wr(5'd12, 32'h0000_8001, 5'd0, 32'h0, 1'b0));
        @(negedge clk); applyStimulus(rd(5'd13, 6'd0, 32'h0, 1'b0));
        found = 0;
        for (int k = 3; k <= 30; k++) begin
            @(posedge clk); #1;
            if (cause_o[30] && found == 0) begin
                found = k;
                checkOutput("timer_int_req", {31'b0, int_req}, 32'h1);
                checkOutput("timer_ip7", {31'b0, cause_o[15]}, 32'h1);
            end
        end
        testsRun++;
        if (!(found == 10 || found == 11)) begin
            testsFailed++;
            $display("[TB] FAIL timer_ti_edge: got %0d, expected 10 or 11", found);
        end
        @(negedge clk); applyStimulus(wr(5'd11, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1));
        @(posedge clk); #1;
        checkOutput("timer_ti_clear", {31'b0, cause_o[30]}, 32'h0);
        checkOutput("timer_int_clear", {31'b0, int_req}, 32'h0);
`else
        // Without the timer, Count/Compare are absent: reads give 0, even
        // with a same-cycle write, and TI never rises.
        @(negedge clk); applyStimulus(wr(5'd9, 32'h1234, 5'd9, 32'h0, 1'b0));
        #1 checkOutput("notimer_count", read_data, 32'h0);
        @(negedge clk); applyStimulus(wr(5'd11, 32'h0, 5'd11, 32'h0, 1'b0));
        #1 checkOutput("notimer_compare", read_data, 32'h0);
        repeat (4) @(posedge clk);
        #1 checkOutput("notimer_ti", {31'b0, cause_o[30]}, 32'h0);
`endif

        // Reset arriving together with an exception and a write must win.
        @(negedge clk);
        applyStimulus(mk(1'b1, 5'd12, 32'hFFFF_FFFF, 5'd0, 1'b1, 5'd4, 32'h1000,
                         1'b0, 32'h2000, 1'b1, 6'b111111, 32'h0, 1'b0));
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_status", status_o, 32'h0040_0000);
        checkOutput("midreset_cause", cause_o, 32'h0);
        checkOutput("midreset_epc", epc_o, 32'h0);
        checkOutput("midreset_int", {31'b0, int_req}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/cp0_regs.md
# cp0_regs

Coprocessor-0 register block at the write-back end of the pipeline. Consumes the CP0 write port leaving the MEM/WB stage, and exception/ERET events from the exception unit. Maintains BadVAddr, Count, Compare, Status, Cause and EPC, and generates the interrupt request. Provides a same-cycle-bypassed read port for MFC0 in EXE.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- wb_cp0_write_enable  in  1  MTC0 commit from MEM/WB.
- wb_cp0_write_addr  in  5  CP0 register number.
- wb_cp0_write_data  in  32  write data.
- read_addr  in  5  MFC0 register number.
- read_data  out  32  MFC0 data, combinational.
- hw_int  in  6  external interrupt lines, level.
- exception  in  1  exception commit, single-cycle pulse.
- exc_code  in  5  ExcCode of the committing exception.
- exc_pc  in  32  PC of the faulting instruction.
- exc_in_delay_slot  in  1  faulting instruction is in a delay slot.
- exc_badvaddr  in  32  faulting address for AdEL/AdES.
- eret  in  1  ERET commit pulse.
- status_o, cause_o, epc_o  out  32 each  current register values.
- int_req  out  1  interrupt pending and enabled.

## Operation
- Registers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Every other address reads 0 and ignores writes.
- Status: bit22 BEV reads 1 and is not writable. Bits 15:8 IM, bit1 EXL and bit0 IE are writable. All other bits read 0.
- Cause:
  - bit31 BD and bit30 TI are read-only.
  - bits 15:10 IP[7:2] are hardware: IP[7] = hw_int[5] | TI; IP[6:2] = hw_int[4:0].
  - bits 9:8 IP[1:0] are software-writable.
  - bits 6:2 ExcCode are set only by exceptions.
- BadVAddr: written only by exceptions with exc_code 4 (AdEL) or 5 (AdES), value exc_badvaddr. MTC0 has no effect.
- EPC, Count, Compare: fully writable.
- Priority per cycle: exception > eret > MTC0. A lower-priority event in the same cycle is dropped entirely.
- Exception:
  - If EXL=0: EPC <= exc_in_delay_slot ? exc_pc-4 : exc_pc, and BD <= exc_in_delay_slot.
  - If EXL=1: EPC and BD are held.
  - Always: EXL <= 1 and ExcCode <= exc_code.
- ERET: EXL <= 0. No other effect.
- Read bypass: if wb_cp0_write_enable is high and wb_cp0_write_addr == read_addr, read_data returns the masked value that write will produce, not the stored value.
- int_req = IE & ~EXL & |(IM & Cause[15:8]).

## Timing
- Reset values:
  - Status 0x0040_0000.
  - Cause, EPC, BadVAddr, Count, Compare 0.
  - Count tick flop 0, sampled hw_int 0.
  - int_req 0, read_data = decode of reset state.
- hw_int is registered once, so it reaches Cause.IP with 1-cycle latency. int_req follows combinationally from registers, so the total is hw_int edge -> int_req after 1 posedge.
- Count: a tick flop toggles every cycle, and Count increments on cycles where tick=1, i.e. once every 2 cycles. Wrap is 0xFFFF_FFFF -> 0 with no flag.
- Count MTC0 takes priority over the increment. The tick flop is unaffected.
- TI set: on the posedge after the stored Count == stored Compare, evaluated on pre-update values. TI then stays set.
- TI clear: MTC0 to Compare clears TI. If a set and a clear coincide in the same cycle, the clear wins.
- Reset mid-operation clears all state on that posedge, regardless of exception, eret or write inputs.

## Configuration
- CP0_TIMER_EN defined: Count/Compare/TI behave as above.
- CP0_TIMER_EN undefined:
  - Count, Compare and the tick flop are removed; addresses 9 and 11 read 0 and ignore writes.
  - TI is constant 0, so IP[7] = hw_int[5].

## Test plan
- Reset, then read addr 12 -> 0x0040_0000. Read addr 13 -> 0. int_req=0.
- MTC0 Status=0xFFFF_FFFF, then read 12 -> 0x0040_FF03. Same-cycle read of 12 during the write -> 0x0040_FF03 (bypass).
- EXL=0: exception, exc_code=4, exc_pc=0xBFC0_0100, delay slot=1, badvaddr=0x1234_5679 -> EPC 0xBFC0_00FC, BD=1, ExcCode 4, BadVAddr 0x1234_5679, EXL=1.
  - Second exception with exc_pc=0x8000_0000 -> EPC unchanged.
  - ERET -> EXL=0.
- Exception and MTC0 EPC=0x5555_5555 in the same cycle -> EPC from exception; the MTC0 is dropped.
- Timer (CP0_TIMER_EN): Compare=5, Count=0, Status=0x0000_8001.
  - TI=1 and int_req=1 about 11 cycles after the writes.
  - MTC0 Compare -> TI=0 and int_req=0 on the next cycle.
- hw_int=6'b000001 with Status IM[2]=1, IE=1 -> Cause bit10=1 and int_req=1 after one posedge. Deassert -> both 0 after one posedge.
